// File: rtl/sha256d_nonce_sched.sv
// Drives one shared single-block SHA-256 core through double-SHA-256 nonce sweeps.
// Each nonce runs pass 1 over {tmpl, nonce}, then pass 2 over the padded digest, then a target compare.
module sha256d_nonce_sched #(
  parameter int CORE_LAT     = 1,
  parameter bit STOP_ON_FIND = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [479:0] job_tmpl,
  input  logic [31:0]  job_nonce_start,
  input  logic [31:0]  job_nonce_end,
  input  logic [255:0] job_target,
  input  logic         abort,
  output logic         core_en,
  output logic [511:0] core_block,
  input  logic [255:0] core_digest,
  output logic         found_valid,
  input  logic         found_ready,
  output logic [31:0]  found_nonce,
  output logic [255:0] found_digest,
  output logic         done,
  output logic         busy,
  output logic [31:0]  hash_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_P1, S_W1, S_P2, S_W2, S_CHK, S_REPORT, S_DONE
  } state_t;

  localparam int            CW   = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CORE_LAT - 1);

  state_t         state_r, state_n_s, state_s;
  logic [CW-1:0]  wait_r;
  logic [31:0]    nonce_r, end_r, nonce_s;
  logic [479:0]   tmpl_r, tmpl_s;
  logic [255:0]   target_r, digest2_r;
  logic           load_s, inc_s, abort_s, hit_s, last_s, wait_done_s;
  logic           job_ready_r, core_en_r, found_valid_r, done_r, busy_r;
  logic [511:0]   core_block_r;
  logic [31:0]    found_nonce_r, hash_count_r;
  logic [255:0]   found_digest_r;

  // Next-state decode; abort from any active state overrides the nominal transition.
  always_comb begin
    state_n_s   = state_r;
    load_s      = 1'b0;
    inc_s       = 1'b0;
    hit_s       = (digest2_r <= target_r);
    last_s      = (nonce_r == end_r);
    wait_done_s = (wait_r == LAST);
    abort_s     = abort && (state_r != S_IDLE);
    case (state_r)
      S_IDLE: begin
        if (job_valid) begin
          load_s = 1'b1;
          if (job_nonce_start > job_nonce_end) state_n_s = S_DONE;
          else                                 state_n_s = S_P1;
        end else begin
          state_n_s = S_IDLE;
        end
      end
      S_P1: state_n_s = S_W1;
      S_W1: begin
        if (wait_done_s) state_n_s = S_P2;
        else             state_n_s = S_W1;
      end
      S_P2: state_n_s = S_W2;
      S_W2: begin
        if (wait_done_s) state_n_s = S_CHK;
        else             state_n_s = S_W2;
      end
      S_CHK: begin
        if (hit_s) begin
          state_n_s = S_REPORT;
        end else if (last_s) begin
          state_n_s = S_DONE;
        end else begin
          state_n_s = S_P1;
          inc_s     = 1'b1;
        end
      end
      S_REPORT: begin
        if (!found_ready) begin
          state_n_s = S_REPORT;
        end else if (STOP_ON_FIND || last_s) begin
          state_n_s = S_DONE;
        end else begin
          state_n_s = S_P1;
          inc_s     = 1'b1;
        end
      end
      S_DONE:  state_n_s = S_IDLE;
      default: state_n_s = S_IDLE;
    endcase

    if (abort_s) state_s = S_IDLE;
    else         state_s = state_n_s;

    if (load_s) begin
      nonce_s = job_nonce_start;
      tmpl_s  = job_tmpl;
    end else if (inc_s && !abort_s) begin
      nonce_s = nonce_r + 32'd1;
      tmpl_s  = tmpl_r;
    end else begin
      nonce_s = nonce_r;
      tmpl_s  = tmpl_r;
    end
  end

  // State, latency counter and status outputs, all registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= S_IDLE;
      wait_r        <= {CW{1'b0}};
      job_ready_r   <= 1'b1;
      core_en_r     <= 1'b0;
      found_valid_r <= 1'b0;
      done_r        <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      job_ready_r   <= (state_s == S_IDLE);
      core_en_r     <= (state_s == S_P1) || (state_s == S_P2);
      found_valid_r <= (state_s == S_REPORT);
      done_r        <= (state_s == S_DONE);
      busy_r        <= (state_s != S_IDLE);
      if (((state_r == S_W1) || (state_r == S_W2)) && (state_s == state_r)) wait_r <= wait_r + 1'b1;
      else                                                                 wait_r <= {CW{1'b0}};
    end
  end

  // Job capture, nonce/count tracking, core block and hit registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmpl_r         <= 480'd0;
      end_r          <= 32'd0;
      target_r       <= 256'd0;
      nonce_r        <= 32'd0;
      hash_count_r   <= 32'd0;
      core_block_r   <= 512'd0;
      digest2_r      <= 256'd0;
      found_nonce_r  <= 32'd0;
      found_digest_r <= 256'd0;
    end else begin
      tmpl_r  <= tmpl_s;
      nonce_r <= nonce_s;
      if (load_s) begin
        end_r        <= job_nonce_end;
        target_r     <= job_target;
        hash_count_r <= 32'd0;
      end else if ((state_r == S_CHK) && !abort_s) begin
        hash_count_r <= hash_count_r + 32'd1;
      end else begin
        hash_count_r <= hash_count_r;
      end
      // Pass 2 block is built straight from the digest on the cycle pass 1 completes.
      if (state_s == S_P1)      core_block_r <= {tmpl_s, nonce_s};
      else if (state_s == S_P2) core_block_r <= {core_digest, 32'h8000_0000, 160'd0, 64'h0000_0000_0000_0100};
      else                      core_block_r <= core_block_r;
      if ((state_r == S_W2) && wait_done_s) digest2_r <= core_digest;
      else                                  digest2_r <= digest2_r;
      if ((state_r == S_CHK) && (state_s == S_REPORT)) begin
        found_nonce_r  <= nonce_r;
        found_digest_r <= digest2_r;
      end else begin
        found_nonce_r  <= found_nonce_r;
        found_digest_r <= found_digest_r;
      end
    end
  end

  assign job_ready    = job_ready_r;
  assign core_en      = core_en_r;
  assign core_block   = core_block_r;
  assign found_valid  = found_valid_r;
  assign found_nonce  = found_nonce_r;
  assign found_digest = found_digest_r;
  assign done         = done_r;
  assign busy         = busy_r;
  assign hash_count   = hash_count_r;

endmodule
